// File: rtl/geofence_pkg.sv
// Shared types and helpers for the geofence controller: FSM state encoding,
// slot-index width sizing and the wrap-around edge successor.
package geofence_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    TEST = 2'd2,
    DONE = 2'd3
  } state_t;

  // Smallest width w with 2**w > n, so slots 0..n are all addressable.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  // The last fence edge closes the polygon back to vertex 1.
  function automatic int next_edge(input int e, input int n);
    return (e == n) ? 1 : e + 1;
  endfunction

endpackage

// File: rtl/geofence_bubble_seq.sv
// Bubble-sort sequencer over slots 2..N_FENCE: one compare per enabled cycle,
// optional early exit after a clean pass; sort_done is combinational with the last compare.
module geofence_bubble_seq
  import geofence_pkg::*;
#(
  parameter int N_FENCE    = 6,
  parameter int EARLY_EXIT = 1,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             swapped,
  output logic [IDX_W-1:0] p1,
  output logic [IDX_W-1:0] p2,
  output logic             sort_done
);

  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N_FENCE - 3);
  localparam logic [IDX_W-1:0] LAST_J0   = IDX_W'(N_FENCE - 1);
  localparam logic [IDX_W-1:0] FIRST_J   = IDX_W'(2);

  logic [IDX_W-1:0] pass_cnt;
  logic [IDX_W-1:0] j;
  logic             swap_seen;
  logic             pass_end;
  logic             any_swap;

  // The swapped flag of the final compare must count toward the early-exit decision.
  assign any_swap  = swap_seen | swapped;
  assign pass_end  = (j == (LAST_J0 - pass_cnt));
  assign sort_done = en & pass_end &
                     ((pass_cnt == LAST_PASS) | ((EARLY_EXIT != 0) & ~any_swap));

  assign p1 = j;
  assign p2 = j + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt  <= '0;
      j         <= '0;
      swap_seen <= 1'b0;
    end else if (start) begin
      pass_cnt  <= '0;
      j         <= FIRST_J;
      swap_seen <= 1'b0;
    end else if (en) begin
      if (pass_end) begin
        pass_cnt  <= pass_cnt + 1'b1;
        j         <= FIRST_J;
        swap_seen <= 1'b0;
      end else begin
        j         <= j + 1'b1;
        swap_seen <= any_swap;
      end
    end
  end

endmodule

// File: rtl/geofence_ctrl_param.sv
// Geofence control FSM: load target+fence, angular sort, per-edge inside test, result strobe.
// Loading stalls on in_valid; valid/is_inside appear one cycle after DONE (first LOAD cycle).
module geofence_ctrl_param
  import geofence_pkg::*;
#(
  parameter int N_FENCE    = 6,
  parameter int EARLY_EXIT = 1,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             swapped,
  input  logic             outside,
  output logic             load,
  output logic [IDX_W-1:0] load_idx,
  output logic             bdctrl,
  output logic [IDX_W-1:0] p1,
  output logic [IDX_W-1:0] p2,
  output logic             busy,
  output logic             valid,
  output logic             is_inside
);

  localparam logic [IDX_W-1:0] N_L = IDX_W'(N_FENCE);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] load_cnt;
  logic [IDX_W-1:0] edge_cnt;
  logic [IDX_W-1:0] seq_p1, seq_p2;
  logic             res_q;
  logic             sort_start;
  logic             sort_done;

  assign sort_start = (state == LOAD) && in_valid && (load_cnt == N_L);

  geofence_bubble_seq #(
    .N_FENCE   (N_FENCE),
    .EARLY_EXIT(EARLY_EXIT),
    .IDX_W     (IDX_W)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (sort_start),
    .en       (bdctrl),
    .swapped  (swapped),
    .p1       (seq_p1),
    .p2       (seq_p2),
    .sort_done(sort_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_idx  = '0;
    bdctrl    = 1'b0;
    busy      = 1'b0;
    p1        = IDX_W'(1);
    p2        = IDX_W'(2);
    case (state)
      LOAD: begin
        load     = 1'b1;
        load_idx = load_cnt;
        if (sort_start) state_nxt = SORT;
      end
      SORT: begin
        bdctrl = 1'b1;
        busy   = 1'b1;
        p1     = seq_p1;
        p2     = seq_p2;
        if (sort_done) state_nxt = TEST;
      end
      TEST: begin
        busy = 1'b1;
        p1   = edge_cnt;
        p2   = IDX_W'(next_edge(int'(edge_cnt), N_FENCE));
        if (outside || (edge_cnt == N_L)) state_nxt = DONE;
      end
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Result registers drop to zero every cycle except the one following DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt  <= '0;
      edge_cnt  <= '0;
      res_q     <= 1'b0;
      valid     <= 1'b0;
      is_inside <= 1'b0;
    end else begin
      valid     <= 1'b0;
      is_inside <= 1'b0;
      case (state)
        LOAD: if (in_valid) load_cnt <= (load_cnt == N_L) ? '0 : load_cnt + 1'b1;
        SORT: if (sort_done) edge_cnt <= IDX_W'(1);
        TEST: begin
          if (outside)               res_q    <= 1'b0;
          else if (edge_cnt == N_L)  res_q    <= 1'b1;
          else                       edge_cnt <= edge_cnt + 1'b1;
        end
        DONE: begin
          valid     <= 1'b1;
          is_inside <= res_q;
          load_cnt  <= '0;
          edge_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
